// File: rtl/array_pack_pkg.sv
// Shared definitions for the serial-to-array packing stage: lane count,
// count width and the fill/hold control states.
package array_pack_pkg;
  localparam int LANES = 5;
  localparam int CNT_W = 3;

  typedef enum logic {FILL, HOLD} state_e;
endpackage

// File: rtl/array_pack_slot.sv
// Output register of the packer: holds lanes, populated-lane count and valid,
// loads on load_i and releases on a downstream accept.
module array_pack_slot
  import array_pack_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        load_i,
  input  logic [LANES-1:0][WIDTH-1:0] lanes_i,
  input  logic [CNT_W-1:0]            count_i,
  input  logic                        ready_i,
  output logic [LANES-1:0][WIDTH-1:0] lanes_o,
  output logic [CNT_W-1:0]            count_o,
  output logic                        valid_o
);

  logic [LANES-1:0][WIDTH-1:0] lanes_q, lanes_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        valid_q, valid_d;

  // A load in the same cycle as an accept keeps valid high with new contents.
  always_comb begin
    valid_d = valid_q;
    lanes_d = lanes_q;
    count_d = count_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      lanes_d = lanes_i;
      count_d = count_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      lanes_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      lanes_q <= lanes_d;
      count_q <= count_d;
    end
  end

  assign lanes_o = lanes_q;
  assign count_o = count_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/array_pack_buffer.sv
// Packs a valid/ready element stream into 5-lane frames; a completed frame
// bypasses the fill buffer into the output slot when the slot is free.
module array_pack_buffer
  import array_pack_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I_data,
  input  logic             I_last,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O_0,
  output logic [WIDTH-1:0] O_1,
  output logic [WIDTH-1:0] O_2,
  output logic [WIDTH-1:0] O_3,
  output logic [WIDTH-1:0] O_4,
  output logic [2:0]       O_count,
  output logic             O_valid,
  input  logic             O_ready
);

  logic [LANES-1:0][WIDTH-1:0] fill_q, frame_lanes, slot_lanes;
  logic [CNT_W-1:0]            cnt_q, cnt_d, slot_count;
  state_e                      state_q, state_d;
  logic                        ready_q;
  logic                        acc, slot_free, complete, load;

  assign acc       = I_valid && ready_q;
  assign slot_free = !O_valid || O_ready;
  assign complete  = acc && ((cnt_q == CNT_W'(LANES - 1)) || I_last);

  // Lanes above the closing element are forced to zero so stale fill data never leaks.
  always_comb begin
    frame_lanes = '0;
    for (int k = 0; k < LANES; k++) begin
      if (CNT_W'(k) < cnt_q)
        frame_lanes[k] = fill_q[k];
      else if (CNT_W'(k) == cnt_q)
        frame_lanes[k] = (state_q == FILL) ? I_data : fill_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      FILL: begin
        if (complete) begin
          if (slot_free) begin
            load  = 1'b1;
            cnt_d = '0;
          end else begin
            state_d = HOLD;
          end
        end else if (acc) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (slot_free) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // I_ready is registered from next state, so O_ready never reaches it combinationally.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= FILL;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == FILL);
    end
  end

  always_ff @(posedge CLK) begin
    if (acc) fill_q[cnt_q] <= I_data;
  end

  array_pack_slot #(.WIDTH(WIDTH)) u_slot (
    .clk_i   (CLK),
    .rst_ni  (ASYNCRESETN),
    .load_i  (load),
    .lanes_i (frame_lanes),
    .count_i (cnt_q + CNT_W'(1)),
    .ready_i (O_ready),
    .lanes_o (slot_lanes),
    .count_o (slot_count),
    .valid_o (O_valid)
  );

  assign I_ready = ready_q;
  assign O_count = slot_count;
  assign O_0     = slot_lanes[0];
  assign O_1     = slot_lanes[1];
  assign O_2     = slot_lanes[2];
  assign O_3     = slot_lanes[3];
  assign O_4     = slot_lanes[4];

endmodule

// File: tb/tb_array_pack_buffer.sv
// Bench for array_pack_buffer: directed scenarios plus random traffic checked
// against a queue-based frame model.
module tb_array_pack_buffer;
  localparam int W = 5;

  logic         CLK = 1'b0;
  logic         ASYNCRESETN;
  logic [W-1:0] I_data;
  logic         I_last, I_valid, I_ready;
  logic [W-1:0] O_0, O_1, O_2, O_3, O_4;
  logic [2:0]   O_count;
  logic         O_valid, O_ready;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int lanes[5];
    int cnt;
  } frame_t;

  frame_t expq[$];
  int     cur[$];

  array_pack_buffer #(.WIDTH(W)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I_data(I_data), .I_last(I_last), .I_valid(I_valid), .I_ready(I_ready),
    .O_0(O_0), .O_1(O_1), .O_2(O_2), .O_3(O_3), .O_4(O_4),
    .O_count(O_count), .O_valid(O_valid), .O_ready(O_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input int a, input int b, input int c,
                           input int d, input int e, input int n);
    chk({tag, ".valid"}, 32'(O_valid), 32'd1);
    chk({tag, ".O_0"}, 32'(O_0), 32'(a));
    chk({tag, ".O_1"}, 32'(O_1), 32'(b));
    chk({tag, ".O_2"}, 32'(O_2), 32'(c));
    chk({tag, ".O_3"}, 32'(O_3), 32'(d));
    chk({tag, ".O_4"}, 32'(O_4), 32'(e));
    chk({tag, ".count"}, 32'(O_count), 32'(n));
  endtask

  task automatic model_push(input int d, input bit last);
    frame_t f;
    cur.push_back(d);
    if (last || cur.size() == 5) begin
      for (int k = 0; k < 5; k++) f.lanes[k] = (k < cur.size()) ? cur[k] : 0;
      f.cnt = cur.size();
      expq.push_back(f);
      cur.delete();
    end
  endtask

  task automatic check_out_front();
    frame_t f;
    logic [31:0] obs[5];
    chk("model.frame_expected", 32'(expq.size() != 0), 32'd1);
    if (expq.size() != 0) begin
      f = expq.pop_front();
      obs = '{32'(O_0), 32'(O_1), 32'(O_2), 32'(O_3), 32'(O_4)};
      for (int k = 0; k < 5; k++) chk($sformatf("model.lane%0d", k), obs[k], 32'(f.lanes[k]));
      chk("model.count", 32'(O_count), 32'(f.cnt));
    end
  endtask

  // One clock: record the transfers the coming edge will perform, then advance.
  task automatic step();
    bit acc, otx;
    acc = I_valid && I_ready;
    otx = O_valid && O_ready;
    if (otx) check_out_front();
    if (acc) model_push(int'(I_data), I_last);
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int d, input bit last);
    I_valid = 1'b1;
    I_data  = W'(d);
    I_last  = last;
    step();
    I_valid = 1'b0;
    I_last  = 1'b0;
  endtask

  initial begin
    bit done;
    ASYNCRESETN = 1'b0;
    I_data = '0; I_last = 1'b0; I_valid = 1'b0; O_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.O_valid", 32'(O_valid), 32'd0);
    chk("reset.I_ready", 32'(I_ready), 32'd0);
    chk("reset.O_count", 32'(O_count), 32'd0);
    chk("reset.lanes", 32'({O_0, O_1, O_2, O_3, O_4}), 32'd0);
    ASYNCRESETN = 1'b1;
    chk("release.I_ready_before_edge", 32'(I_ready), 32'd0);
    step();
    chk("release.I_ready_after_edge", 32'(I_ready), 32'd1);

    // Full frame with downstream always ready
    O_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send(i, 1'b0);
    chk_frame("full", 1, 2, 3, 4, 5, 5);
    step();
    chk("full.one_cycle", 32'(O_valid), 32'd0);

    // Short frame closed by I_last
    send(7, 1'b0);
    send(9, 1'b1);
    chk_frame("short", 7, 9, 0, 0, 0, 2);
    step();
    chk("short.one_cycle", 32'(O_valid), 32'd0);

    // Backpressure: A in slot, B held in fill
    O_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(i, 1'b0);
    for (int i = 6; i <= 10; i++) send(i, 1'b0);
    chk("hold.I_ready", 32'(I_ready), 32'd0);
    chk_frame("hold.A_stable", 1, 2, 3, 4, 5, 5);
    I_valid = 1'b1; I_data = W'(31);
    step();
    I_valid = 1'b0;
    chk_frame("hold.A_still", 1, 2, 3, 4, 5, 5);
    O_ready = 1'b1;
    chk("hold.no_comb_ready", 32'(I_ready), 32'd0);
    step();
    chk_frame("hold.B", 6, 7, 8, 9, 10, 5);
    chk("hold.exit_I_ready", 32'(I_ready), 32'd1);
    step();
    chk("hold.B_gone", 32'(O_valid), 32'd0);

    // Short frame through the HOLD path must not leak stale fill lanes
    O_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(i, 1'b0);
    send(8, 1'b1);
    chk("hold_short.I_ready", 32'(I_ready), 32'd0);
    O_ready = 1'b1;
    step();
    chk_frame("hold_short", 8, 0, 0, 0, 0, 1);
    step();

    // Simultaneous transfer and load
    O_ready = 1'b0;
    for (int i = 11; i <= 19; i++) send(i, 1'b0);
    chk_frame("simul.C", 11, 12, 13, 14, 15, 5);
    O_ready = 1'b1;
    send(20, 1'b0);
    chk_frame("simul.D", 16, 17, 18, 19, 20, 5);
    chk("simul.I_ready", 32'(I_ready), 32'd1);
    step();
    chk("simul.D_gone", 32'(O_valid), 32'd0);

    // Reset mid-fill with a frame pending in the slot
    O_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(i, 1'b0);
    for (int i = 21; i <= 23; i++) send(i, 1'b0);
    ASYNCRESETN = 1'b0;
    #1;
    chk("midreset.O_valid", 32'(O_valid), 32'd0);
    chk("midreset.lanes", 32'({O_0, O_1, O_2, O_3, O_4}), 32'd0);
    chk("midreset.I_ready", 32'(I_ready), 32'd0);
    cur.delete();
    expq.delete();
    @(posedge CLK);
    #1;
    ASYNCRESETN = 1'b1;
    step();
    chk("midreset.I_ready_after", 32'(I_ready), 32'd1);
    O_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send(i, 1'b0);
    chk_frame("midreset.frame", 1, 2, 3, 4, 5, 5);
    send(3, 1'b1);
    chk_frame("after_full.single", 3, 0, 0, 0, 0, 1);
    step();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      I_valid = ($urandom_range(0, 3) != 0);
      I_data  = W'($urandom);
      I_last  = ($urandom_range(0, 3) == 0);
      O_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // Close any partial frame and drain
    done = 1'b0;
    I_valid = 1'b1; I_last = 1'b1; I_data = W'(1); O_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (I_ready) done = 1'b1;
      step();
    end
    I_valid = 1'b0; I_last = 1'b0;
    chk("drain.accepted", 32'(done), 32'd1);
    repeat (4) step();
    chk("drain.no_pending_frames", 32'(expq.size()), 32'd0);
    chk("drain.no_partial", 32'(cur.size()), 32'd0);
    chk("drain.O_valid", 32'(O_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
